// File: rtl/key_controller.sv
// key_controller: sequencing controller for the 32-bit password register.
//
// Collects keypad digits into a 32-bit entry shift register and compares them
// against the stored password. A match opens the lock for UNLOCK_CYCLES cycles.
// While the lock is open a new password can be entered, and it is written to the
// register with a two-cycle write handshake.
//
// Optional feature (macro KEY_CTRL_LOCKOUT_EN): counts consecutive rejected codes.
// After MAX_FAIL of them the controller enters a LOCKOUT of LOCKOUT_CYCLES cycles.
// Without the macro, a rejected code always returns to idle and locked_out is 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   digit_valid, digit   keypad digit strobe and 4-bit value
//   enter, cancel        submit / abort strobes (cancel > enter > digit)
//   change_req           password change request, honoured only while open
//   keyPass              stored password read back from the register
//   keyEnable            register enable (check and write phases)
//   readKey              1 = read, 0 = write-enable
//   keyBuffer            new password driven to the register
//   unlocked             lock open
//   locked_out           lockout active
//   fail_pulse           one-cycle pulse on a rejected code
//   busy                 controller not idle
// All outputs are registered.
module key_controller #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned UNLOCK_CYCLES  = 256,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        cancel,
  input  logic        change_req,
  input  logic [31:0] keyPass,
  output logic        keyEnable,
  output logic        readKey,
  output logic [31:0] keyBuffer,
  output logic        unlocked,
  output logic        locked_out,
  output logic        fail_pulse,
  output logic        busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StEntry    = 3'd1;
  localparam logic [2:0] StCheck    = 3'd2;
  localparam logic [2:0] StOpen     = 3'd3;
  localparam logic [2:0] StNewEntry = 3'd4;
  localparam logic [2:0] StWrArm    = 3'd5;
  localparam logic [2:0] StWrData   = 3'd6;
  localparam logic [2:0] StLockout  = 3'd7;

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DIGITS);

  // One timer serves both OPEN and LOCKOUT, so size it for the longer of the two.
  localparam int unsigned TmrMax = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                    : UNLOCK_CYCLES;
  localparam int unsigned TmrW = (TmrMax > 2) ? $clog2(TmrMax) : 1;
  // Loaded with N-1 so the state lasts exactly N cycles (leaves when the timer reads 0).
  localparam logic [TmrW-1:0] UnlockLoad = TmrW'(UNLOCK_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [31:0]     entry_q, entry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            pulse_d;
  logic            take_digit;
  logic            code_match;

  logic            key_enable_q;
  logic            read_key_q;
  logic [31:0]     key_buffer_q;
  logic            unlocked_q;
  logic            fail_pulse_q;
  logic            busy_q;

`ifdef KEY_CTRL_LOCKOUT_EN
  localparam int unsigned FailW = $clog2(MAX_FAIL + 1);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAIL);
  localparam logic [TmrW-1:0] LockLoad = TmrW'(LOCKOUT_CYCLES - 1);

  logic [FailW-1:0] fail_cnt_q, fail_cnt_d;
  logic             locked_out_q;
`else
  // MAX_FAIL only matters when the lockout feature is built.
  logic unused_max_fail;
  assign unused_max_fail = (MAX_FAIL != 0);
`endif

  assign code_match = (cnt_q == CntFull) && (entry_q == keyPass);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    tmr_d      = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    pulse_d    = 1'b0;
    take_digit = 1'b0;
`ifdef KEY_CTRL_LOCKOUT_EN
    fail_cnt_d = fail_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (digit_valid) begin
          take_digit = 1'b1;
          state_d    = StEntry;
        end
      end
      StEntry: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (enter) begin
          state_d = StCheck;
        end else if (digit_valid) begin
          take_digit = 1'b1;
        end
      end
      StCheck: begin
        if (code_match) begin
          state_d = StOpen;
          tmr_d   = UnlockLoad;
`ifdef KEY_CTRL_LOCKOUT_EN
          fail_cnt_d = '0;
`endif
        end else begin
          pulse_d = 1'b1;
          state_d = StIdle;
`ifdef KEY_CTRL_LOCKOUT_EN
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_d >= FailMax) begin
            state_d = StLockout;
            tmr_d   = LockLoad;
          end
`endif
        end
      end
      StOpen: begin
        if (cancel || (tmr_q == '0)) begin
          state_d = StIdle;
        end else if (change_req) begin
          state_d = StNewEntry;
        end
      end
      StNewEntry: begin
        if (cancel) begin
          state_d = StOpen;
        end else if (enter) begin
          if (cnt_q == CntFull) begin
            state_d = StWrArm;
          end else begin
            // Short new password: reject, timer keeps running.
            pulse_d = 1'b1;
            state_d = StOpen;
          end
        end else if (digit_valid) begin
          take_digit = 1'b1;
        end
      end
      StWrArm:  state_d = StWrData;
      StWrData: state_d = StIdle;
      StLockout: begin
`ifdef KEY_CTRL_LOCKOUT_EN
        if (tmr_q == '0) begin
          state_d    = StIdle;
          fail_cnt_d = '0;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (take_digit && (cnt_q != CntFull)) begin
      entry_d = {entry_q[27:0], digit};
      cnt_d   = cnt_q + 1'b1;
    end

    // Entering IDLE, OPEN or NEW_ENTRY starts a fresh code.
    if ((state_d != state_q) &&
        ((state_d == StIdle) || (state_d == StOpen) || (state_d == StNewEntry))) begin
      entry_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      entry_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_enable_q <= 1'b0;
      read_key_q   <= 1'b1;
      key_buffer_q <= '0;
      unlocked_q   <= 1'b0;
      fail_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      key_enable_q <= (state_d == StCheck) || (state_d == StWrArm) || (state_d == StWrData);
      // Write-enable spans WR_ARM and WR_DATA; keyBuffer only changes in WR_DATA.
      read_key_q   <= !((state_d == StWrArm) || (state_d == StWrData));
      if (state_d == StWrData) begin
        key_buffer_q <= entry_q;
      end
      unlocked_q   <= (state_d == StOpen) || (state_d == StNewEntry);
      fail_pulse_q <= pulse_d;
      busy_q       <= (state_d != StIdle);
    end
  end

`ifdef KEY_CTRL_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_q   <= '0;
      locked_out_q <= 1'b0;
    end else begin
      fail_cnt_q   <= fail_cnt_d;
      locked_out_q <= (state_d == StLockout);
    end
  end

  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

  assign keyEnable  = key_enable_q;
  assign readKey    = read_key_q;
  assign keyBuffer  = key_buffer_q;
  assign unlocked   = unlocked_q;
  assign fail_pulse = fail_pulse_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_key_controller.sv
// Self-checking bench for key_controller. The password register is emulated
// here; a transaction-level model predicts the outcome of every code entry.
module tb_key_controller;

  localparam int Digits    = 8;
  localparam int MaxFail   = 3;
  localparam int UnlockLen = 256;
  localparam int LockLen   = 1024;
`ifdef KEY_CTRL_LOCKOUT_EN
  localparam bit LockoutBuilt = 1'b1;
`else
  localparam bit LockoutBuilt = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic        enter = 1'b0;
  logic        cancel = 1'b0;
  logic        change_req = 1'b0;
  logic [31:0] pw_reg = 32'h0;
  logic        keyEnable, readKey, unlocked, locked_out, fail_pulse, busy;
  logic [31:0] keyBuffer;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] pw = 32'h0;
  logic [31:0] kb = 32'h0;
  int          fails = 0;
  bit          lockout_en = LockoutBuilt;

  key_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_valid(digit_valid),
    .digit      (digit),
    .enter      (enter),
    .cancel     (cancel),
    .change_req (change_req),
    .keyPass    (pw_reg),
    .keyEnable  (keyEnable),
    .readKey    (readKey),
    .keyBuffer  (keyBuffer),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_pulse (fail_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Password register: latches keyBuffer when enabled for write.
  always @(posedge clk) begin
    if (keyEnable === 1'b1 && readKey === 1'b0) pw_reg <= keyBuffer;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic wait_open();
    int cyc;
    cyc = 1;
    while (unlocked === 1'b1 && cyc < 3000) begin
      tick();
      if (unlocked === 1'b1) cyc++;
    end
    check("unlock_len", cyc, UnlockLen);
    check("open_expired_idle", busy, 0);
  endtask

  task automatic wait_lockout();
    int cyc;
    cyc = 1;
    // Keypad keeps typing during lockout; every digit must be ignored.
    while (locked_out === 1'b1 && cyc < 3000) begin
      press(4'($urandom_range(0, 15)));
      if (locked_out === 1'b1) cyc++;
    end
    check("lockout_len", cyc, LockLen);
    check("lockout_ends_idle", busy, 0);
  endtask

  // Checks DUT outputs 2 cycles after enter against the model's prediction.
  task automatic expect_result(input logic [63:0] code, input int n, input bit keep,
                               output bit opened);
    logic [31:0] ent;
    bit          exp_lock;
    ent = (n >= Digits) ? 32'(code >> (4 * (n - Digits))) : 32'h0;
    opened = (n >= Digits) && (ent == pw);
    if (opened) begin
      fails = 0;
      check("unlock", unlocked, 1);
      check("no_fail_pulse", fail_pulse, 0);
      check("no_lockout_on_match", locked_out, 0);
      if (!keep) begin
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_closes", unlocked, 0);
        check("cancel_idle", busy, 0);
      end
    end else begin
      fails++;
      exp_lock = lockout_en && (fails >= MaxFail);
      check("fail_pulse", fail_pulse, 1);
      check("stay_locked", unlocked, 0);
      check("locked_out", locked_out, exp_lock);
      check("busy_after_fail", busy, exp_lock);
      if (exp_lock) begin
        fails = 0;
        wait_lockout();
      end else begin
        tick();
        check("pulse_one_cycle", fail_pulse, 0);
      end
    end
  endtask

  task automatic attempt(input logic [63:0] code, input int n, input bit keep,
                         output bit opened);
    for (int i = 0; i < n; i++) press(code[4*(n-1-i) +: 4]);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    expect_result(code, n, keep, opened);
  endtask

  // Called while open.
  task automatic change_pw(input logic [31:0] np, input int n);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    check("new_entry_open", unlocked, 1);
    for (int i = 0; i < n; i++) press(np[4*(n-1-i) +: 4]);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    if (n == Digits) begin
      check("arm_readkey", readKey, 0);
      check("arm_keyenable", keyEnable, 1);
      check("arm_buf_hold", keyBuffer, kb);
      tick();
      check("data_readkey", readKey, 0);
      check("data_buf", keyBuffer, np);
      tick();
      check("write_done_readkey", readKey, 1);
      check("write_done_idle", busy, 0);
      check("write_done_closed", unlocked, 0);
      pw = np;
      kb = np;
      check("reg_written", pw_reg, pw);
    end else begin
      check("short_new_pulse", fail_pulse, 1);
      check("short_stays_open", unlocked, 1);
      check("short_no_write", readKey, 1);
      tick();
      check("short_pulse_one", fail_pulse, 0);
      check("short_still_open", unlocked, 1);
    end
  endtask

  initial begin
    bit          o;
    logic [63:0] code;
    int          n;

    // Reset state
    tick();
    tick();
    check("rst_keyenable", keyEnable, 0);
    check("rst_readkey", readKey, 1);
    check("rst_keybuffer", keyBuffer, 0);
    check("rst_unlocked", unlocked, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_fail_pulse", fail_pulse, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Default password 0 opens for the full unlock time
    attempt(64'h0, 8, 1'b1, o);
    check("default_pw_opens", o, 1);
    wait_open();

    // Change password to 12345678
    attempt(64'h0, 8, 1'b1, o);
    change_pw(32'h1234_5678, 8);
    attempt(64'h1234_5678, 8, 1'b0, o);
    check("new_pw_opens", o, 1);
    attempt(64'h0, 8, 1'b0, o);

    // Short code
    attempt(64'h12345, 5, 1'b0, o);

    // Cancel in ENTRY leaves the fail count alone
    for (int i = 0; i < 4; i++) press(4'(i + 1));
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_entry_idle", busy, 0);
    tick();
    check("cancel_no_pulse", fail_pulse, 0);

    // Digit together with enter is dropped: only 7 digits reach the check
    code = {36'h0, pw[31:4]};
    for (int i = 0; i < 7; i++) press(code[4*(6-i) +: 4]);
    enter = 1'b1;
    digit_valid = 1'b1;
    digit = pw[3:0];
    tick();
    enter = 1'b0;
    digit_valid = 1'b0;
    tick();
    expect_result(code, 7, 1'b0, o);

    // Three wrong codes in a row
    for (int k = 0; k < 3; k++) attempt({32'h0, pw ^ 32'h1}, 8, 1'b0, o);

    // Short new password is rejected without a write
    attempt({32'h0, pw}, 8, 1'b1, o);
    change_pw(32'h0009_8765, 5);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("short_cancel_idle", busy, 0);

    // Reset during WR_DATA
    attempt({32'h0, pw}, 8, 1'b1, o);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    code = 64'hCAFE_F00D;
    for (int i = 0; i < 8; i++) press(code[4*(7-i) +: 4]);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    check("pre_reset_buf", keyBuffer, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_readkey", readKey, 1);
    check("mid_rst_keybuffer", keyBuffer, 0);
    check("mid_rst_keyenable", keyEnable, 0);
    check("mid_rst_unlocked", unlocked, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fail_pulse", fail_pulse, 0);
    check("mid_rst_locked_out", locked_out, 0);
    tick();
    tick();
    rst_n = 1'b1;
    kb = 32'h0;
    fails = 0;
    tick();
    check("reg_not_written", pw_reg, pw);
    attempt({32'h0, pw}, 8, 1'b0, o);
    check("old_pw_after_reset", o, 1);

    // Randomized entries against the model
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0: begin n = 8; code = {32'h0, pw}; end
        1: begin
          n = $urandom_range(9, 10);
          code = ({32'h0, pw} << (4 * (n - 8))) | 64'($urandom_range(0, 255));
        end
        2: begin n = $urandom_range(1, 7); code = {32'h0, $urandom()}; end
        default: begin n = 8; code = {32'h0, $urandom()}; end
      endcase
      attempt(code, n, 1'b1, o);
      if (o) begin
        if ($urandom_range(0, 2) == 0) begin
          change_pw($urandom(), 8);
        end else begin
          cancel = 1'b1;
          tick();
          cancel = 1'b0;
          check("rand_cancel_idle", busy, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_controller.md
# key_controller

Sequencing controller for the 32-bit password register block. Collects keypad digits, compares the entered code against the stored password and opens the lock on a match. While the lock is open, it lets the user write a new password into the register. It also counts consecutive failures and can enforce a timed lockout. It sits between the keypad front end and the password register, and is the only agent that drives the register's `keyEnable`, `readKey` and `keyBuffer` inputs.

## Interface
- `DIGITS`, 8: digits per code; 4 bits each; `DIGITS*4` must equal 32.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout.
- `UNLOCK_CYCLES`, 256: cycles `unlocked` stays high.
- `LOCKOUT_CYCLES`, 1024: lockout duration in cycles.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digit_valid`  in  1  one-cycle strobe; `digit` is valid this cycle.
- `digit`  in  4  keypad digit, 0x0–0xF.
- `enter`  in  1  one-cycle strobe; submit the collected code.
- `cancel`  in  1  one-cycle strobe; abort entry.
- `change_req`  in  1  one-cycle strobe; request a password change (honoured only in OPEN).
- `keyPass`  in  32  stored password, read from the password register.
- `keyEnable`  out  1  enables the password register; high in CHECK, WR_ARM and WR_DATA.
- `readKey`  out  1  1 = read; 0 = write-enable to the password register.
- `keyBuffer`  out  32  new password value driven to the password register.
- `unlocked`  out  1  lock open.
- `locked_out`  out  1  lockout active.
- `fail_pulse`  out  1  one-cycle pulse on a rejected code.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, NEW_ENTRY, WR_ARM, WR_DATA, LOCKOUT.
- Entry shift register, 32 bits: `entry <= {entry[27:0], digit}` on each accepted digit.
  - Digit count saturates at `DIGITS`; further digits are ignored.
  - The shift register and the count are cleared whenever a state enters IDLE, OPEN or NEW_ENTRY.
- IDLE: `digit_valid` accepts the digit and moves to ENTRY. `enter`, `cancel` and `change_req` are ignored.
- ENTRY:
  - `digit_valid` accepts the digit.
  - `enter` moves to CHECK.
  - `cancel` moves to IDLE without counting a failure.
- CHECK, one cycle. The code matches when count == `DIGITS` and `entry == keyPass`.
  - Match: clear the fail counter and go to OPEN.
  - No match: pulse `fail_pulse` and increment the fail counter.
  - If the counter reaches `MAX_FAIL`, go to LOCKOUT; otherwise go to IDLE.
- OPEN: `unlocked` = 1 while the timer runs.
  - `change_req` moves to NEW_ENTRY.
  - Timer expiry or `cancel` moves to IDLE.
- NEW_ENTRY: `unlocked` stays 1; digits are collected as in ENTRY.
  - `enter` with count == `DIGITS` moves to WR_ARM.
  - `enter` with a short count pulses `fail_pulse` and returns to OPEN. This does not count as a failure, and the timer is not restarted.
  - `cancel` moves to OPEN.
- WR_ARM: `readKey` = 0; `keyBuffer` is held at its old value.
- WR_DATA: `readKey` = 0; `keyBuffer <= entry`. Next state is IDLE.
- LOCKOUT: `locked_out` = 1 and all inputs are ignored.
  - On timer expiry, clear the fail counter and go to IDLE.
- Priority within a cycle: `cancel` > `enter` > `digit_valid`. A digit that arrives with `enter` is dropped.
- A timer down-counter is shared by OPEN and LOCKOUT. It is loaded on entry to either state and restarted only on a fresh entry from CHECK.

## Timing
- Reset values:
  - State IDLE; fail counter, timer, `entry` and count all 0.
  - `keyBuffer` = 0, `readKey` = 1.
  - `keyEnable`, `unlocked`, `locked_out`, `fail_pulse` and `busy` all 0.
- All outputs are registered. Reset mid-operation, including during WR_ARM or WR_DATA, returns to IDLE at once and forces `readKey` = 1.
- Latency:
  - `enter` in ENTRY → CHECK the next cycle.
  - `unlocked`, `locked_out` or `fail_pulse` are visible 2 cycles after the `enter` edge.
- `unlocked` stays high for exactly `UNLOCK_CYCLES` cycles if no other event occurs.
- `locked_out` stays high for exactly `LOCKOUT_CYCLES` cycles.
- Write handshake: `readKey` falls one cycle before `keyBuffer` changes and rises the cycle after. This guarantees the password register sees write-enable when `keyBuffer` changes.

## Configuration
- `KEY_CTRL_LOCKOUT_EN`, when defined:
  - The fail counter, the LOCKOUT state and `locked_out` behave as described above.
- When undefined:
  - The fail counter and the LOCKOUT state are not built; `locked_out` is tied to 0.
  - A mismatch always returns to IDLE. `fail_pulse` is still generated.

## Test plan
- Reset, then digits 0 ×8, then `enter` → `unlocked` = 1 for 256 cycles, then IDLE. The reset password is 0x00000000.
- In OPEN: `change_req`, digits 1..8, `enter` → `readKey` low for 2 cycles and `keyBuffer` = 0x12345678. A later entry of 1..8 unlocks; an entry of 0 ×8 gives `fail_pulse`.
- Three wrong 8-digit codes → `fail_pulse` ×3 and `locked_out` = 1 for 1024 cycles; digits during lockout are ignored. With the macro undefined, `locked_out` stays 0.
- 5 digits then `enter` → `fail_pulse` and back to IDLE. `enter` and `digit_valid` together → the digit is dropped. `cancel` in ENTRY → IDLE with the fail counter unchanged.
- `rst_n` low during WR_DATA → `readKey` = 1, `keyBuffer` = 0, state IDLE, all outputs 0.
